// File: rtl/mbox_cache_cycle_arbiter_if.sv
// Request, strobe and grant signals between the MBOX requesters/sequencer and the cycle arbiter.
// The arbiter takes the slave side; requesters and the cache sequencer take the master side.
interface mbox_cache_cycle_arbiter_if;
   logic mb_req;
   logic cca_req;
   logic chan_req;
   logic ebox_req;
   logic page_fail_hold;
   logic cyc_done;
   logic cyc_abort;
   logic err_clr;
   logic mb_grant;
   logic cca_grant;
   logic chan_grant;
   logic ebox_grant;
   logic mb_cyc;
   logic cca_cyc;
   logic chan_cyc;
   logic ebox_cyc;
   logic cyc_t0;
   logic ebox_retry_req;
   logic busy;
   logic timeout_err;

   modport master (
      output mb_req, cca_req, chan_req, ebox_req, page_fail_hold,
             cyc_done, cyc_abort, err_clr,
      input  mb_grant, cca_grant, chan_grant, ebox_grant,
             mb_cyc, cca_cyc, chan_cyc, ebox_cyc,
             cyc_t0, ebox_retry_req, busy, timeout_err
   );

   modport slave (
      input  mb_req, cca_req, chan_req, ebox_req, page_fail_hold,
             cyc_done, cyc_abort, err_clr,
      output mb_grant, cca_grant, chan_grant, ebox_grant,
             mb_cyc, cca_cyc, chan_cyc, ebox_cyc,
             cyc_t0, ebox_retry_req, busy, timeout_err
   );
endinterface

// File: rtl/mbox_cache_cycle_arbiter.sv
// Arbitrates the shared MBOX cache cycle path among MB, CCA, CHAN and EBOX; owner held until done/abort/timeout.
// Latency: request sampled in IDLE -> grant pulse next cycle; minimum grant-to-grant spacing of 4 cycles.
// Backpressure: level requests are not latched; losers simply keep requesting until sampled in IDLE.
module mbox_cache_cycle_arbiter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8,
   parameter int EBOX_STARVE    = 4
) (
   input logic                         clk,
   input logic                         reset_n,
   mbox_cache_cycle_arbiter_if.slave   bus
);

   localparam int SW = $clog2(EBOX_STARVE + 1);
   localparam logic [SW-1:0]    STARVE_MAX = SW'(EBOX_STARVE);
   localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, RECOVER} state_t;

   // owner vectors are one-hot: bit0 MB, bit1 CCA, bit2 CHAN, bit3 EBOX
   state_t           state_q, state_d;
   logic [3:0]       owner_q, owner_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             err_q, err_d;
   logic             retry_d;
   logic             ebox_el;
   logic [3:0]       winner;

   logic [3:0]       grant_q, cyc_q;
   logic             t0_q, retry_q, busy_q;

   always_comb begin
      ebox_el = bus.ebox_req & ~bus.page_fail_hold;
      winner  = 4'b0000;
      if (bus.mb_req)
         winner = 4'b0001;
      else if (ebox_el && starve_q == STARVE_MAX)
         winner = 4'b1000;
      else if (bus.cca_req)
         winner = 4'b0010;
      else if (bus.chan_req)
         winner = 4'b0100;
      else if (ebox_el)
         winner = 4'b1000;
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      starve_d = starve_q;
      wd_d     = wd_q;
      retry_d  = 1'b0;
      err_d    = err_q & ~bus.err_clr;
      case (state_q)
         IDLE: begin
            if (|winner) begin
               owner_d = winner;
               state_d = GRANT;
            end
            if (winner[3] || !ebox_el)
               starve_d = '0;
            else if ((winner[1] || winner[2]) && starve_q != STARVE_MAX)
               starve_d = starve_q + SW'(1);
         end
         GRANT: begin
            wd_d    = '0;
            state_d = ACTIVE;
         end
         ACTIVE: begin
            wd_d = wd_q + CNT_W'(1);
            // done outranks abort, which outranks the watchdog
            if (bus.cyc_done) begin
               state_d = RECOVER;
            end else if (bus.cyc_abort) begin
               state_d = RECOVER;
               retry_d = owner_q[3];
            end else if (wd_q == WD_LAST) begin
               state_d = RECOVER;
               err_d   = 1'b1;
            end
         end
         RECOVER: begin
            owner_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         starve_q <= '0;
         wd_q     <= '0;
         err_q    <= 1'b0;
         grant_q  <= '0;
         cyc_q    <= '0;
         t0_q     <= 1'b0;
         retry_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         wd_q     <= wd_d;
         err_q    <= err_d;
         grant_q  <= (state_d == GRANT) ? owner_d : 4'b0000;
         cyc_q    <= (state_d == GRANT || state_d == ACTIVE) ? owner_d : 4'b0000;
         t0_q     <= (state_d == GRANT);
         retry_q  <= retry_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   assign bus.mb_grant       = grant_q[0];
   assign bus.cca_grant      = grant_q[1];
   assign bus.chan_grant     = grant_q[2];
   assign bus.ebox_grant     = grant_q[3];
   assign bus.mb_cyc         = cyc_q[0];
   assign bus.cca_cyc        = cyc_q[1];
   assign bus.chan_cyc       = cyc_q[2];
   assign bus.ebox_cyc       = cyc_q[3];
   assign bus.cyc_t0         = t0_q;
   assign bus.ebox_retry_req = retry_q;
   assign bus.busy           = busy_q;
   assign bus.timeout_err    = err_q;

endmodule

// File: tb/tb_mbox_cache_cycle_arbiter.sv
// Randomized and directed bench for the MBOX cache cycle arbiter against a transaction-level model.
module tb_mbox_cache_cycle_arbiter;

   localparam int TMO    = 8;
   localparam int STARVE = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   starve_m = 0;
   logic err_m = 1'b0;

   mbox_cache_cycle_arbiter_if bus ();

   mbox_cache_cycle_arbiter #(
      .TIMEOUT_CYCLES(TMO),
      .CNT_W(4),
      .EBOX_STARVE(STARVE)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] grants();
      return {bus.ebox_grant, bus.chan_grant, bus.cca_grant, bus.mb_grant};
   endfunction

   function automatic logic [3:0] cycs();
      return {bus.ebox_cyc, bus.chan_cyc, bus.cca_cyc, bus.mb_cyc};
   endfunction

   function automatic logic [11:0] outs();
      return {grants(), cycs(), bus.cyc_t0, bus.ebox_retry_req, bus.busy, bus.timeout_err};
   endfunction

   // Priority list model: MB first, then EBOX if starved, then CCA, CHAN, EBOX.
   function automatic logic [3:0] model_pick(input logic [3:0] el);
      int order[4];
      if (starve_m == STARVE && el[3]) order = '{0, 3, 1, 2};
      else                             order = '{0, 1, 2, 3};
      foreach (order[i])
         if (el[order[i]]) return 4'(1 << order[i]);
      return 4'b0000;
   endfunction

   task automatic set_reqs(input logic [3:0] rq);
      bus.mb_req   = rq[0];
      bus.cca_req  = rq[1];
      bus.chan_req = rq[2];
      bus.ebox_req = rq[3];
   endtask

   // One full arbitration from IDLE; nact ACTIVE cycles with dn/ab strobed in the last, none => timeout.
   task automatic do_txn(input logic [3:0] rq, input logic pf, input int nact,
                         input logic dn, input logic ab, output logic [3:0] got);
      logic [3:0] el, exp;
      logic       exp_retry;
      el = {rq[3] & ~pf, rq[2:0]};
      set_reqs(rq);
      bus.page_fail_hold = pf;
      got = 4'b0000;
      if (el == 4'b0000) begin
         step();
         n_chk++;
         if (bus.busy !== 1'b0 || grants() !== 4'b0000)
            $display("FAIL idle_no_req: busy=%b grants=%b, required busy=0 grants=0000", bus.busy, grants());
         else n_pass++;
         starve_m = 0;
         return;
      end
      exp = model_pick(el);
      if (!el[3] || exp[3])       starve_m = 0;
      else if (exp[1] || exp[2]) starve_m = (starve_m < STARVE) ? starve_m + 1 : STARVE;

      step();
      got = grants();
      n_chk++;
      if (got !== exp) $display("FAIL grant: got %b, required %b (req %b pf %b)", got, exp, rq, pf);
      else n_pass++;
      n_chk++;
      if ({cycs(), bus.cyc_t0, bus.busy} !== {exp, 2'b11})
         $display("FAIL grant_cycle: cyc/t0/busy=%b, required %b", {cycs(), bus.cyc_t0, bus.busy}, {exp, 2'b11});
      else n_pass++;

      // changes during the owned cycle must not matter; done/abort in GRANT is ignored
      set_reqs(4'($urandom));
      bus.page_fail_hold = 1'($urandom);
      bus.cyc_done  = 1'($urandom);
      bus.cyc_abort = 1'($urandom);
      for (int i = 1; i <= nact; i++) begin
         step();
         bus.cyc_done  = 1'b0;
         bus.cyc_abort = 1'b0;
         if (i == nact) begin
            bus.cyc_done  = dn;
            bus.cyc_abort = ab;
         end
         n_chk++;
         if ({grants(), cycs(), bus.cyc_t0, bus.ebox_retry_req, bus.busy} !== {4'b0000, exp, 3'b001})
            $display("FAIL active[%0d]: grant/cyc/t0/retry/busy=%b, required %b", i,
                     {grants(), cycs(), bus.cyc_t0, bus.ebox_retry_req, bus.busy}, {4'b0000, exp, 3'b001});
         else n_pass++;
      end

      step();
      bus.cyc_done  = 1'b0;
      bus.cyc_abort = 1'b0;
      exp_retry = ab && !dn && exp[3];
      if (!dn && !ab) err_m = 1'b1;
      n_chk++;
      if ({grants(), cycs(), bus.ebox_retry_req, bus.busy, bus.timeout_err} !== {8'h00, exp_retry, 1'b1, err_m})
         $display("FAIL recover: grant/cyc/retry/busy/err=%b, required %b",
                  {grants(), cycs(), bus.ebox_retry_req, bus.busy, bus.timeout_err},
                  {8'h00, exp_retry, 1'b1, err_m});
      else n_pass++;

      set_reqs(4'b0000);
      step();
      bus.page_fail_hold = 1'b0;
      n_chk++;
      if ({cycs(), bus.ebox_retry_req, bus.busy} !== 6'b0)
         $display("FAIL back_to_idle: cyc/retry/busy=%b, required 000000", {cycs(), bus.ebox_retry_req, bus.busy});
      else n_pass++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_reqs(4'b1111);
      bus.page_fail_hold = 1'b0;
      bus.cyc_done  = 1'b0;
      bus.cyc_abort = 1'b0;
      bus.err_clr   = 1'b0;
      repeat (3) step();
      n_chk++;
      if (outs() !== 12'h000) $display("FAIL reset_outputs: got %h, required 000", outs());
      else n_pass++;
      set_reqs(4'b0000);
      reset_n = 1'b1;
      step();
      n_chk++;
      if (outs() !== 12'h000) $display("FAIL post_reset_idle: got %h, required 000", outs());
      else n_pass++;
   endtask

   task automatic test_single();
      logic [3:0] got;
      do_txn(4'b1000, 1'b0, 3, 1'b1, 1'b0, got);
   endtask

   task automatic test_priority();
      logic [3:0] got;
      logic [3:0] pend;
      logic [3:0] order[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
      starve_m = 0;
      do_txn(4'b0000, 1'b0, 1, 1'b1, 1'b0, got);
      pend = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         do_txn(pend, 1'b0, 1, 1'b1, 1'b0, got);
         n_chk++;
         if (got !== order[i]) $display("FAIL priority_order[%0d]: got %b, required %b", i, got, order[i]);
         else n_pass++;
         pend = pend & ~(got & 4'b0011);
      end
   endtask

   task automatic test_page_fail();
      logic [3:0] got;
      set_reqs(4'b1000);
      bus.page_fail_hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_chk++;
         if (bus.busy !== 1'b0 || grants() !== 4'b0000)
            $display("FAIL page_fail_block[%0d]: busy=%b grants=%b, required 0/0000", i, bus.busy, grants());
         else n_pass++;
      end
      starve_m = 0;
      do_txn(4'b1000, 1'b0, 2, 1'b1, 1'b0, got);
   endtask

   task automatic test_abort();
      logic [3:0] got;
      do_txn(4'b1000, 1'b0, 2, 1'b0, 1'b1, got);
      do_txn(4'b0100, 1'b0, 2, 1'b0, 1'b1, got);
      do_txn(4'b1000, 1'b0, 1, 1'b1, 1'b1, got);
   endtask

   task automatic test_watchdog();
      logic [3:0] got;
      bus.err_clr = 1'b0;
      do_txn(4'b0100, 1'b0, TMO, 1'b0, 1'b0, got);
      repeat (3) step();
      n_chk++;
      if (bus.timeout_err !== 1'b1) $display("FAIL err_sticky: got %b, required 1", bus.timeout_err);
      else n_pass++;
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      err_m = 1'b0;
      n_chk++;
      if (bus.timeout_err !== 1'b0) $display("FAIL err_clr: got %b, required 0", bus.timeout_err);
      else n_pass++;
      do_txn(4'b0100, 1'b0, TMO, 1'b1, 1'b0, got);
      bus.err_clr = 1'b1;
      do_txn(4'b0010, 1'b0, TMO, 1'b0, 1'b0, got);
      n_chk++;
      if (bus.timeout_err !== 1'b0) $display("FAIL err_clr_after_set: got %b, required 0", bus.timeout_err);
      else n_pass++;
      bus.err_clr = 1'b0;
      err_m = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] got;
      for (int i = 0; i < 6 && starve_m < STARVE; i++)
         do_txn(4'b1100, 1'b0, 1, 1'b1, 1'b0, got);
      set_reqs(4'b1001);
      step();
      n_chk++;
      if (grants() !== 4'b0001) $display("FAIL mb_over_starved: got %b, required 0001", grants());
      else n_pass++;
      set_reqs(4'b0000);
      step();
      bus.cyc_abort = 1'b1;
      reset_n = 1'b0;
      step();
      n_chk++;
      if (outs() !== 12'h000) $display("FAIL reset_mid_active: got %h, required 000", outs());
      else n_pass++;
      reset_n = 1'b1;
      bus.cyc_abort = 1'b0;
      starve_m = 0;
      err_m = 1'b0;
      do_txn(4'b1010, 1'b0, 1, 1'b1, 1'b0, got);
      n_chk++;
      if (got !== 4'b0010) $display("FAIL starve_cleared_by_reset: got %b, required 0010", got);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [3:0] got;
      logic [3:0] rq;
      int mode;
      for (int i = 0; i < 60; i++) begin
         rq = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) rq[3] = 1'b1;
         mode = $urandom_range(0, 2);
         do_txn(rq, 1'($urandom_range(0, 3) == 0), $urandom_range(1, 6),
                mode != 1, mode != 0, got);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_page_fail();
      test_abort();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mbox_cache_cycle_arbiter.md
Name: mbox_cache_cycle_arbiter

Overview:
- Sequences the shared MBOX cache/memory cycle path between four requesters: MB writeback, CCA sweep, channel and EBOX.
- Issues one-hot grant pulses and per-owner cycle levels, which drive the CSH REQ_GRANT and *_CYC strobes.
- Holds ownership until the cache sequencer reports done or abort.
- Adds EBOX anti-starvation, page-fail blocking, EBOX retry signalling and a cycle watchdog.

Parameters:
- TIMEOUT_CYCLES, 255: maximum ACTIVE cycles before a forced cycle end and error.
- CNT_W, 8: width of the watchdog counter. Must satisfy 2**CNT_W > TIMEOUT_CYCLES.
- EBOX_STARVE, 4: number of consecutive CCA/CHAN grants taken while the EBOX is eligible before the EBOX is promoted.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- reset_n  in  1  synchronous reset, active low.
- mb_req  in  1  MB writeback request, level.
- cca_req  in  1  cache clear/sweep request, level.
- chan_req  in  1  channel request, level.
- ebox_req  in  1  EBOX request, level.
- page_fail_hold  in  1  blocks EBOX eligibility while high.
- cyc_done  in  1  sequencer end-of-cycle strobe; sampled only in ACTIVE.
- cyc_abort  in  1  sequencer abort strobe; sampled only in ACTIVE.
- err_clr  in  1  clears timeout_err.
- mb_grant, cca_grant, chan_grant, ebox_grant  out  1 each  one-cycle grant pulses; at most one high.
- mb_cyc, cca_cyc, chan_cyc, ebox_cyc  out  1 each  owner level; at most one high.
- cyc_t0  out  1  first-cycle strobe; coincident with the grant pulse.
- ebox_retry_req  out  1  one-cycle pulse after an aborted EBOX cycle.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- All outputs are registered. Reset value of every output is 0; state = IDLE; counters = 0; owner = none.
- Reset asserted mid-cycle drops all grants and cyc levels on the next edge. No retry pulse and no error are produced.
- Eligibility: mb_req, cca_req and chan_req are eligible as given. EBOX is eligible when ebox_req && !page_fail_hold.
- Priority: MB > CCA > CHAN > EBOX. When starve_cnt == EBOX_STARVE and the EBOX is eligible, priority becomes MB > EBOX > CCA > CHAN. MB is never preempted.
- starve_cnt:
  - Increments, saturating at EBOX_STARVE, on each CCA or CHAN grant issued while the EBOX is eligible.
  - Clears on an EBOX grant, or on any IDLE cycle where the EBOX is not eligible.
- FSM:
  - IDLE: if any requester is eligible, latch the winner as owner and go to GRANT. Otherwise stay.
  - GRANT (1 cycle): <owner>_grant=1, cyc_t0=1, <owner>_cyc=1, watchdog cleared. Go to ACTIVE.
  - ACTIVE: <owner>_cyc=1 and the watchdog increments every cycle.
    - cyc_done=1 goes to RECOVER (normal end).
    - Otherwise cyc_abort=1 goes to RECOVER; if owner is EBOX, set retry_pending.
    - Otherwise watchdog == TIMEOUT_CYCLES-1 goes to RECOVER and sets timeout_err.
    - Otherwise stay.
  - RECOVER (1 cycle): all cyc levels 0. ebox_retry_req = retry_pending, then retry_pending is cleared. Owner is cleared. Go to IDLE.
- Same-cycle precedence in ACTIVE: done > abort > timeout. Done together with abort gives no retry. Done on the timeout cycle gives no error.
- Latency and spacing:
  - Request first eligible in IDLE at edge N gives grant high during cycle N+1.
  - The earliest done is sampled at N+2. RECOVER occupies N+3 and IDLE N+4. The next grant is at N+5, so the minimum spacing between grants is 4 cycles.
- Requests are not latched. A request dropped before the IDLE sample is lost. Requester changes during GRANT, ACTIVE or RECOVER do not affect the current owner.
- page_fail_hold rising during an EBOX cycle has no effect on that cycle.
- timeout_err: set as above; cleared by err_clr in IDLE or any state. If set and err_clr arrive in the same cycle, set wins.

Test Plan:
- Single request: ebox_req=1 only, cyc_done at the 3rd ACTIVE cycle → ebox_grant and cyc_t0 pulse at N+1; ebox_cyc high N+1..N+4; busy low at N+6.
- Priority: all four requests held at once → grant order MB, CCA, CHAN, CHAN, CHAN, then EBOX. After MB drops, the 4th non-EBOX grant promotes EBOX, and CCA/CHAN never win once starve_cnt = 4.
- Page-fail: ebox_req=1 with page_fail_hold=1 for 10 cycles → no grant and busy stays 0. Releasing the hold → ebox_grant 1 cycle after the release is sampled.
- Abort: EBOX owner with cyc_abort=1 → ebox_retry_req pulse in RECOVER. Same abort on a CHAN owner → no pulse. cyc_done and cyc_abort together → no pulse.
- Watchdog: TIMEOUT_CYCLES=8 with cyc_done never asserted → cyc drops after 8 ACTIVE cycles and timeout_err=1 sticky; err_clr → 0. Done on the 8th cycle → no error.
- Reset mid-ACTIVE: reset_n=0 for one cycle → all outputs 0 at the next edge, FSM in IDLE, starve_cnt=0, no retry pulse.
